mainmem_resp: RTL and testbench

MAINMEM_RESP -- requirements
Module: mainmem_resp

---
 rtl/mainmem_resp_if.sv | 28 ++
 rtl/mainmem_resp.sv | 147 ++++++++++++++
 tb/tb_mainmem_resp.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mainmem_resp_if.sv
// mainmem_resp_if -- request/status signals between the cache controller
// and the main-memory responder.
//   addr_mem  : block address (controller -> memory)
//   rd_mem    : block read request
//   wr_mem    : block write request
//   ready_mem : memory idle / able to accept a request
//   err_mem   : one-cycle pulse on an illegal request
// The shared data byte bus is a tristate net and is carried as a direct
// inout port of the memory so every driver resolves on a single net.
interface mainmem_resp_if #(
    parameter int AWIDTH = 16
);
    logic [AWIDTH-1:0] addr_mem;
    logic              rd_mem;
    logic              wr_mem;
    logic              ready_mem;
    logic              err_mem;

    modport master (
        output addr_mem, rd_mem, wr_mem,
        input  ready_mem, err_mem
    );

    modport slave (
        input  addr_mem, rd_mem, wr_mem,
        output ready_mem, err_mem
    );
endinterface

// File: rtl/mainmem_resp.sv
// mainmem_resp -- block-transfer main-memory model for a cache controller.
// Holds a 2^AWIDTH byte array (not cleared by reset) and serves 4-beat
// block reads and writes over a shared tristate byte bus.
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of mainmem_resp_if (addr/rd/wr in, ready/err out)
//   data_mem : shared byte bus; driven only while a read burst is in flight
// Read : ready low for LATENCY cycles, one turnaround cycle with the bus
//        released, then bytes base+0..base+3 on consecutive cycles.
// Write: bytes captured on the accept edge and the three following edges,
//        then ready held low for LATENCY more cycles.
module mainmem_resp #(
    parameter int AWIDTH    = 16,
    parameter int DWIDTH    = 8,
    parameter int BLOCKSIZE = 4,
    parameter int LATENCY   = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    mainmem_resp_if.slave     bus,
    inout  wire  [DWIDTH-1:0] data_mem
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RDLAT   = 3'd1;
    localparam logic [2:0] RDTA    = 3'd2;
    localparam logic [2:0] RDBURST = 3'd3;
    localparam logic [2:0] WRCAP   = 3'd4;
    localparam logic [2:0] WRLAT   = 3'd5;

    localparam logic [1:0] LAST_BEAT = 2'(BLOCKSIZE - 1);
    localparam logic [3:0] LAT_LOAD  = 4'(LATENCY - 1);

    logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

    logic [2:0]        state;
    logic [3:0]        lat_cnt;
    logic [1:0]        beat;
    logic [AWIDTH-3:0] base;
    logic              ready_q;
    logic              err_q;

    logic              req_ok;
    logic              acc_wr;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_waddr;
    logic              unused_addr_lsb;

    // Beat index lives in the two low address bits only, so the request's
    // own low bits never reach the array.
    assign unused_addr_lsb = ^bus.addr_mem[1:0];

    assign req_ok = (state == IDLE) && ready_q;
    assign acc_wr = req_ok && bus.wr_mem && !bus.rd_mem;

    // Byte 0 of a write lands on the accept edge, before base is latched,
    // so its address comes straight from the request.
    assign mem_we    = reset_n && (acc_wr || (state == WRCAP));
    assign mem_waddr = (state == IDLE) ? {bus.addr_mem[AWIDTH-1:2], 2'b00}
                                       : {base, beat};

    always_ff @(posedge clock) begin
        if (mem_we)
            mem[mem_waddr] <= data_mem;
    end

    assign data_mem = (state == RDBURST) ? mem[{base, beat}] : {DWIDTH{1'bz}};

    assign bus.ready_mem = ready_q;
    assign bus.err_mem   = err_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            lat_cnt <= '0;
            beat    <= '0;
            base    <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_ok) begin
                        if (bus.rd_mem && bus.wr_mem) begin
                            err_q <= 1'b1;
                        end else if (bus.rd_mem) begin
                            base    <= bus.addr_mem[AWIDTH-1:2];
                            ready_q <= 1'b0;
                            lat_cnt <= LAT_LOAD;
                            state   <= RDLAT;
                        end else if (bus.wr_mem) begin
                            base    <= bus.addr_mem[AWIDTH-1:2];
                            ready_q <= 1'b0;
                            beat    <= 2'd1;
                            state   <= WRCAP;
                        end
                    end
                end
                RDLAT: begin
                    // Loaded with LATENCY-1 so ready rises exactly LATENCY
                    // edges after acceptance.
                    if (lat_cnt == 4'd0) begin
                        ready_q <= 1'b1;
                        state   <= RDTA;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                RDTA: begin
                    beat  <= 2'd0;
                    state <= RDBURST;
                end
                RDBURST: begin
                    if (beat == LAST_BEAT) begin
                        beat  <= 2'd0;
                        state <= IDLE;
                    end else begin
                        beat <= beat + 2'd1;
                    end
                end
                WRCAP: begin
                    if (beat == LAST_BEAT) begin
                        beat    <= 2'd0;
                        lat_cnt <= LAT_LOAD;
                        state   <= WRLAT;
                    end else begin
                        beat <= beat + 2'd1;
                    end
                end
                WRLAT: begin
                    if (lat_cnt == 4'd0) begin
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mainmem_resp.sv
// tb_mainmem_resp -- directed bench for mainmem_resp. The bus net pulls
// high, so a released bus reads as 8'hFF; no test data uses that byte.
module tb_mainmem_resp;
    localparam int LAT = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       tb_drv;
    logic [7:0] tb_data;
    tri1  [7:0] data_mem;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mainmem_resp_if #(.AWIDTH(16)) bus();

    assign data_mem = tb_drv ? tb_data : 8'hzz;

    mainmem_resp #(.AWIDTH(16), .DWIDTH(8), .BLOCKSIZE(4), .LATENCY(LAT)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .bus      (bus),
        .data_mem (data_mem)
    );

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [31:0] data;   // byte 0 in [31:24]
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input string nm);
        int low = 0;
        @(negedge clock);
        bus.addr_mem = a; bus.wr_mem = 1'b1; tb_drv = 1'b1; tb_data = d[31:24];
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            bus.wr_mem = 1'b0;
            if (i <= 3) tb_data = d[31-8*i -: 8];
            else        tb_drv  = 1'b0;
            if (bus.ready_mem) break;
            low++;
        end
        tb_drv = 1'b0;
        chk({nm, "_wr_low"}, low, 3 + LAT);
    endtask

    // now=1 presents the request at the current negedge instead of the next.
    task automatic do_read(input logic [15:0] a, input logic [31:0] exp,
                           input bit chk_data, input bit hold, input bit now,
                           input string nm);
        int          low = 0;
        bit          drv_low = 0;
        bit          rdy_burst = 1;
        logic [31:0] got;
        if (!now) @(negedge clock);
        bus.addr_mem = a; bus.rd_mem = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (!hold) bus.rd_mem = 1'b0;
            if (bus.ready_mem) break;
            low++;
            if (data_mem !== 8'hFF) drv_low = 1;
        end
        chk({nm, "_rd_low"}, low, LAT);
        chk({nm, "_lat_bus_z"}, drv_low, 0);
        chk({nm, "_ta_bus_z"}, data_mem, 8'hFF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            got[31-8*k -: 8] = data_mem;
            if (!bus.ready_mem) rdy_burst = 0;
        end
        chk({nm, "_burst_ready"}, rdy_burst, 1);
        if (chk_data) chk({nm, "_data"}, got, exp);
        @(negedge clock);
        chk({nm, "_post_bus_z"}, data_mem, 8'hFF);
        if (hold) chk({nm, "_post_ready"}, bus.ready_mem, 1);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (!bus.ready_mem && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk({nm, "_drain_ready"}, bus.ready_mem, 1);
        repeat (6) @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b1, 16'h1236, 32'hAABBCCDD};
        vecs[1] = '{1'b0, 16'h1235, 32'hAABBCCDD};
        vecs[2] = '{1'b1, 16'hFFFF, 32'h11223344};
        vecs[3] = '{1'b0, 16'hFFFC, 32'h11223344};
        vecs[4] = '{1'b1, 16'h0001, 32'h55667788};
        vecs[5] = '{1'b0, 16'h0002, 32'h55667788};
        vecs[6] = '{1'b1, 16'h1238, 32'h99A0B0C0};
        vecs[7] = '{1'b0, 16'h1237, 32'hAABBCCDD};
        vecs[8] = '{1'b0, 16'h123B, 32'h99A0B0C0};

        reset_n = 1'b0;
        bus.addr_mem = '0; bus.rd_mem = 1'b0; bus.wr_mem = 1'b0;
        tb_drv = 1'b0; tb_data = '0;

        // Reset state, then a read on the very first edge after release.
        repeat (2) @(negedge clock);
        chk("rst_ready", bus.ready_mem, 1);
        chk("rst_err", bus.err_mem, 0);
        chk("rst_bus_z", data_mem, 8'hFF);
        @(negedge clock);
        reset_n = 1'b1;
        do_read(16'h0040, 32'h0, 0, 0, 1, "first");

        // Table: writes and read-backs, including block-boundary addresses.
        for (int v = 0; v < 9; v++) begin
            if (vecs[v].is_wr) do_write(vecs[v].addr, vecs[v].data, $sformatf("v%0d", v));
            else do_read(vecs[v].addr, vecs[v].data, 1, 0, 0, $sformatf("v%0d", v));
        end

        // Simultaneous read and write: error pulse, no state change.
        @(negedge clock);
        bus.addr_mem = 16'h1234; bus.rd_mem = 1'b1; bus.wr_mem = 1'b1;
        tb_drv = 1'b1; tb_data = 8'h5A;
        @(negedge clock);
        chk("err_pulse", bus.err_mem, 1);
        chk("err_ready", bus.ready_mem, 1);
        bus.rd_mem = 1'b0; bus.wr_mem = 1'b0; tb_drv = 1'b0;
        @(negedge clock);
        chk("err_clear", bus.err_mem, 0);
        chk("err_bus_z", data_mem, 8'hFF);
        chk("err_ready2", bus.ready_mem, 1);
        do_read(16'h1234, 32'hAABBCCDD, 1, 0, 0, "err_rb");

        // rd_mem held through a whole read: next accept only once back in IDLE.
        do_read(16'h1238, 32'h99A0B0C0, 1, 1, 0, "hold");
        @(negedge clock);
        chk("hold_reaccept", bus.ready_mem, 0);
        bus.rd_mem = 1'b0;
        drain("hold");

        // Reset while byte 1 of a burst is on the bus.
        @(negedge clock);
        bus.addr_mem = 16'h1234; bus.rd_mem = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            bus.rd_mem = 1'b0;
            if (bus.ready_mem) break;
        end
        @(negedge clock);
        chk("mid_b0", data_mem, 8'hAA);
        @(negedge clock);
        chk("mid_b1", data_mem, 8'hBB);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_bus_z", data_mem, 8'hFF);
        chk("mid_rst_ready", bus.ready_mem, 1);
        chk("mid_rst_err", bus.err_mem, 0);
        @(negedge clock);
        reset_n = 1'b1;
        do_read(16'h1234, 32'hAABBCCDD, 1, 0, 0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
